scan_sequencer: RTL and testbench

//   Time-multiplexed select generator for 8-way output scanning (LED/7-seg digit strobes).

---
 rtl/scan_sequencer.sv | 129 ++++++++++++
 tb/tb_scan_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan select generator: steps sel through 0..last_q, dwelling DIV clocks per index, with all outputs registered.
// Optional blanking gap between indices is enabled with SCAN_BLANK_EN. There is no backpressure: the sequencer free-runs while en=1.
module scan_sequencer #(
    parameter int DIV       = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] num_digits,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       frame_start
);

    localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1
`ifdef SCAN_BLANK_EN
        ,BLANK = 2'd2
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    last_q, last_n;
    logic [2:0]    sel_n;
    logic          valid_n;
    logic          fs_n;
    logic          wrap;
    logic [2:0]    adv_sel;

    // sel >= last_q also covers the 7->0 wrap, so one path handles frame end
    assign wrap    = (sel >= last_q);
    assign adv_sel = wrap ? 3'd0 : sel + 3'd1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_q;
        sel_n   = sel;
        valid_n = sel_valid;
        fs_n    = 1'b0;
        case (state)
            IDLE: begin
                sel_n   = 3'd0;
                valid_n = 1'b0;
                cnt_n   = '0;
                if (en) begin
                    state_n = SHOW;
                    valid_n = 1'b1;
                    fs_n    = 1'b1;
                    last_n  = num_digits;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_n = IDLE;
                    sel_n   = 3'd0;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == DIV_LAST) begin
                    cnt_n = '0;
`ifdef SCAN_BLANK_EN
                    state_n = BLANK;
                    valid_n = 1'b0;
`else
                    sel_n = adv_sel;
                    fs_n  = wrap;
                    if (wrap) last_n = num_digits;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!en) begin
                    state_n = IDLE;
                    sel_n   = 3'd0;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == BLANK_LAST) begin
                    cnt_n   = '0;
                    state_n = SHOW;
                    valid_n = 1'b1;
                    sel_n   = adv_sel;
                    fs_n    = wrap;
                    if (wrap) last_n = num_digits;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                sel_n   = 3'd0;
                valid_n = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_q      <= 3'd0;
            sel         <= 3'd0;
            sel_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_q      <= last_n;
            sel         <= sel_n;
            sel_valid   <= valid_n;
            frame_start <= fs_n;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (DIV=4, BLANK_CYC=2); y is the one-hot decode of sel.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] num_digits;
    logic [2:0] sel;
    logic       sel_valid;
    logic       frame_start;
    logic [7:0] y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DIV(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .num_digits (num_digits),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .frame_start(frame_start)
    );

    assign y = 8'd1 << sel;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [2:0] s, input logic v, input logic f);
        logic [7:0] ey;
        ey = 8'd1 << s;
        chk("sel", sel, s);
        chk("sel_valid", sel_valid, v);
        chk("frame_start", frame_start, f);
        chk("y", y, ey);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
`ifdef SCAN_BLANK_EN
        num_digits = 3'd1;
`else
        num_digits = 3'd7;
`endif
        step(); expect_out(3'd0, 1'b0, 1'b0);
        step(); expect_out(3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(); expect_out(3'd0, 1'b1, 1'b1);

`ifdef SCAN_BLANK_EN
        for (int i = 1; i < 4; i++) begin step(); expect_out(3'd0, 1'b1, 1'b0); end
        for (int i = 0; i < 2; i++) begin step(); expect_out(3'd0, 1'b0, 1'b0); end
        for (int i = 0; i < 4; i++) begin step(); expect_out(3'd1, 1'b1, 1'b0); end
        for (int i = 0; i < 2; i++) begin step(); expect_out(3'd1, 1'b0, 1'b0); end
        step(); expect_out(3'd0, 1'b1, 1'b1);
        step(); expect_out(3'd0, 1'b1, 1'b0);
`else
        // full 8-index frame
        for (int d = 0; d < 8; d++)
            for (int k = 0; k < 4; k++) begin
                expect_out(3'(d), 1'b1, (d == 0) && (k == 0));
                step();
            end
        expect_out(3'd0, 1'b1, 1'b1);

        // en drop mid-dwell at sel=3, then restart with num_digits=2
        step(13); expect_out(3'd3, 1'b1, 1'b0);
        en = 1'b0;
        step(); expect_out(3'd0, 1'b0, 1'b0);
        step(); expect_out(3'd0, 1'b0, 1'b0);
        en = 1'b1; num_digits = 3'd2;
        step(); expect_out(3'd0, 1'b1, 1'b1);

        // 3-index frame; num_digits change mid-frame applies next frame
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 4; k++) begin
                if (d == 1 && k == 0) num_digits = 3'd5;
                expect_out(3'(d), 1'b1, (d == 0) && (k == 0));
                step();
            end
        for (int d = 0; d < 6; d++)
            for (int k = 0; k < 4; k++) begin
                expect_out(3'(d), 1'b1, (d == 0) && (k == 0));
                step();
            end
        expect_out(3'd0, 1'b1, 1'b1);

        // en=0 on the dwell-expiry edge wins
        step(3);
        en = 1'b0;
        step(); expect_out(3'd0, 1'b0, 1'b0);
        en = 1'b1;
        step(); expect_out(3'd0, 1'b1, 1'b1);

        // reset mid-dwell at sel=5
        step(22); expect_out(3'd5, 1'b1, 1'b0);
        reset = 1'b1;
        step(); expect_out(3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(); expect_out(3'd0, 1'b1, 1'b1);
        step(); expect_out(3'd0, 1'b1, 1'b0);

        // num_digits=0: sel pinned at 0, frame_start every DIV clocks
        en = 1'b0;
        step();
        num_digits = 3'd0; en = 1'b1;
        step(); expect_out(3'd0, 1'b1, 1'b1);
        step(3); expect_out(3'd0, 1'b1, 1'b0);
        step(); expect_out(3'd0, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
